cache_gnt_port: RTL and testbench
=================================

CACHE_GNT_PORT -- requirements
Module: cache_gnt_port

Interface
REQ-001 SHALL have parameter N_CLI, default 7, number of clients; equals the arbiter WIDTH.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width; byte stride per beat = DATA_W/8.
REQ-004 SHALL have parameter LEN_W, default 4, burst-length field width.
REQ-005 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port gnt  in  N_CLI  one-hot grant from the round-robin arbiter.
REQ-008 SHALL have port cli_we  in  N_CLI  per-client write flag.
REQ-009 SHALL have port cli_addr  in  N_CLI*ADDR_W  per-client base address, client i at slice i.
REQ-010 SHALL have port cli_len  in  N_CLI*LEN_W  per-client beats minus one.
REQ-011 SHALL have port cli_wdata  in  N_CLI*DATA_W  per-client write data for the current beat.
REQ-012 SHALL have port cli_beat  out  LEN_W  current beat index of the owner.
REQ-013 SHALL have port cli_rvalid  out  N_CLI  one-hot read-data strobe to the owner.
REQ-014 SHALL have port cli_rdata  out  DATA_W  read data, broadcast to all clients.
REQ-015 SHALL have port cli_done  out  N_CLI  one-cycle end pulse to the owner; wired to arbiter req_end.
REQ-016 SHALL have port mem_valid/mem_ready/mem_we/mem_addr/mem_wdata  out/in/out/out/out  1/1/1/ADDR_W/DATA_W  downstream beat request, accepted on valid&ready.
REQ-017 SHALL have port mem_rvalid/mem_rdata  in  1/DATA_W  per-beat response; read data, or write acknowledge.
REQ-018 SHALL have port err  out  1  sticky protocol-error flag.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-020 In IDLE with gnt exactly one-hot, SHALL capture owner index, we and len, and clear beat to 0; next state ISSUE.
REQ-021 In IDLE with gnt zero, SHALL stay in IDLE; with gnt multi-hot, SHALL stay in IDLE and set err.
REQ-022 In ISSUE, SHALL assert mem_valid with mem_addr = owner base + beat*(DATA_W/8), wrapping modulo 2^ADDR_W.
REQ-023 In ISSUE, mem_wdata SHALL be the owner's cli_wdata, combinational, and mem_we SHALL be the captured we.
REQ-024 In ISSUE, request fields SHALL stay stable until mem_ready; on valid&ready the next state SHALL be WAIT.
REQ-025 In WAIT on mem_rvalid: for a read, SHALL drive cli_rvalid[owner]=1 and cli_rdata=mem_rdata in the same cycle.
REQ-026 In WAIT on mem_rvalid: if beat==len, next state SHALL be DONE; otherwise beat increments and next state SHALL be ISSUE.
REQ-027 In DONE, SHALL drive cli_done[owner]=1 for exactly one cycle, then go to IDLE.
REQ-028 Back-to-back grants SHALL have a minimum IDLE gap of one cycle.
REQ-029 gnt changes after capture SHALL be ignored until IDLE.
REQ-030 mem_rvalid outside WAIT SHALL be dropped and SHALL set err.
REQ-031 A single-beat burst (len=0) SHALL take at least 3 cycles from IDLE capture to DONE.
REQ-032 All cli_* outputs other than cli_rdata and cli_beat SHALL be zero when the owner is not being served.

Reset
REQ-033 While rst=1, the FSM SHALL be IDLE and beat, owner, err, mem_valid, cli_rvalid and cli_done SHALL all be 0.
REQ-034 A reset mid-burst SHALL abort the burst with no cli_done pulse; the issuing side SHALL reset the arbiter together with this block.

Structure
REQ-035 The state enum and the default widths SHALL live in the shared package cache_pkg.
REQ-036 The one-hot-to-index and multi-hot detection SHALL be the sub-module cache_oh2idx.

Verification
REQ-037 The bench SHALL cover: gnt=0000100, read, len=0, addr=0x100, mem_rdata=0xDEAD -> mem_addr=0x100, cli_rvalid[2] with 0xDEAD, then cli_done=0000100 for one cycle.
REQ-038 The bench SHALL cover: gnt=0000001, write, len=3, addr=0x40, mem_ready held low 2 cycles per beat -> addresses 0x40/0x44/0x48/0x4C, stable fields while stalled, cli_beat 0..3, one cli_done.
REQ-039 The bench SHALL cover: addr=0xFFFFFFFC, len=1 -> second beat address 0x00000000.
REQ-040 The bench SHALL cover: gnt=0000011 in IDLE -> no mem_valid, err=1 and sticky.
REQ-041 The bench SHALL cover: mem_rvalid pulse in IDLE -> err=1, no cli_rvalid.
REQ-042 The bench SHALL cover: rst asserted in WAIT of a len=2 burst -> next cycle IDLE, all outputs 0, no cli_done; then a fresh grant completes normally.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared state encoding and default widths for the cache grant port.
package cache_pkg;

  localparam int unsigned DEF_N_CLI  = 7;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_LEN_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cache_oh2idx.sv
// Grant vector decode: binary index of the set bit, exactly-one and multi-hot flags.
module cache_oh2idx #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned IDX_W = 3
) (
  input  logic [WIDTH-1:0] onehot_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             one_o,
  output logic             multi_o
);

  // OR of set-bit indices; only meaningful when exactly one bit is set
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (onehot_i[i]) idx_o = idx_o | IDX_W'(i);
    end
  end

  assign multi_o = |(onehot_i & (onehot_i - WIDTH'(1)));
  assign one_o   = (|onehot_i) & ~multi_o;

endmodule

// File: rtl/cache_gnt_port.sv
// Serves the arbiter-granted client's burst as per-beat downstream memory requests.
module cache_gnt_port
  import cache_pkg::*;
#(
  parameter int unsigned N_CLI  = DEF_N_CLI,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CLI-1:0]        gnt,
  input  logic [N_CLI-1:0]        cli_we,
  input  logic [N_CLI*ADDR_W-1:0] cli_addr,
  input  logic [N_CLI*LEN_W-1:0]  cli_len,
  input  logic [N_CLI*DATA_W-1:0] cli_wdata,
  output logic [LEN_W-1:0]        cli_beat,
  output logic [N_CLI-1:0]        cli_rvalid,
  output logic [DATA_W-1:0]       cli_rdata,
  output logic [N_CLI-1:0]        cli_done,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic                    mem_rvalid,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    err
);

  localparam int unsigned IDX_W  = (N_CLI > 1) ? $clog2(N_CLI) : 1;
  localparam int unsigned STRIDE = DATA_W / 8;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               we_q, we_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic               err_q, err_d;

  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_one;
  logic               gnt_multi;

  logic [ADDR_W-1:0]  addr_a  [N_CLI];
  logic [LEN_W-1:0]   len_a   [N_CLI];
  logic [DATA_W-1:0]  wdata_a [N_CLI];

  for (genvar g = 0; g < int'(N_CLI); g++) begin : g_unpack
    assign addr_a[g]  = cli_addr[g*ADDR_W +: ADDR_W];
    assign len_a[g]   = cli_len[g*LEN_W +: LEN_W];
    assign wdata_a[g] = cli_wdata[g*DATA_W +: DATA_W];
  end

  cache_oh2idx #(
    .WIDTH (N_CLI),
    .IDX_W (IDX_W)
  ) u_oh2idx (
    .onehot_i (gnt),
    .idx_o    (gnt_idx),
    .one_o    (gnt_one),
    .multi_o  (gnt_multi)
  );

  // State and burst-context registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      we_q    <= 1'b0;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // Next-state and per-state outputs; request fields are zero outside ISSUE
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    len_d      = len_q;
    beat_d     = beat_q;
    err_d      = err_q | (mem_rvalid & (state_q != ST_WAIT));
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cli_rvalid = '0;
    cli_done   = '0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_one) begin
          owner_d = gnt_idx;
          we_d    = cli_we[gnt_idx];
          len_d   = len_a[gnt_idx];
          beat_d  = '0;
          state_d = ST_ISSUE;
        end else if (gnt_multi) begin
          err_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_a[owner_q] + ADDR_W'(beat_q) * ADDR_W'(STRIDE);
        mem_wdata = wdata_a[owner_q];
        if (mem_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          if (!we_q) cli_rvalid[owner_q] = 1'b1;
          if (beat_q == len_q) begin
            state_d = ST_DONE;
          end else begin
            beat_d  = beat_q + LEN_W'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        cli_done[owner_q] = 1'b1;
        state_d           = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cli_beat  = beat_q;
  assign cli_rdata = mem_rdata;
  assign err       = err_q;

endmodule

// File: tb/tb_cache_gnt_port.sv
// Directed bench for cache_gnt_port: bursts, stalls, address wrap, error and reset cases.
module tb_cache_gnt_port;

  localparam int unsigned N  = 7;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    gnt;
  logic [N-1:0]    cli_we;
  logic [N*AW-1:0] cli_addr;
  logic [N*LW-1:0] cli_len;
  logic [N*DW-1:0] cli_wdata;
  logic [LW-1:0]   cli_beat;
  logic [N-1:0]    cli_rvalid;
  logic [DW-1:0]   cli_rdata;
  logic [N-1:0]    cli_done;
  logic            mem_valid;
  logic            mem_ready;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic            err;

  int n_chk  = 0;
  int n_fail = 0;

  cache_gnt_port #(
    .N_CLI  (N),
    .ADDR_W (AW),
    .DATA_W (DW),
    .LEN_W  (LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gnt        (gnt),
    .cli_we     (cli_we),
    .cli_addr   (cli_addr),
    .cli_len    (cli_len),
    .cli_wdata  (cli_wdata),
    .cli_beat   (cli_beat),
    .cli_rvalid (cli_rvalid),
    .cli_rdata  (cli_rdata),
    .cli_done   (cli_done),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cli(input int c, input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l);
    cli_we[c]           = we;
    cli_addr[c*AW +: AW] = a;
    cli_len[c*LW +: LW]  = l;
  endtask

  // Called at a falling edge; returns at a falling edge with the FSM in IDLE.
  task automatic run_burst(input int c, input logic we, input logic [AW-1:0] base, input int len,
                           input int stall, input logic [DW-1:0] rbase, input logic [N-1:0] ghold);
    logic [N-1:0]    oh;
    logic [AW-1:0]   exp_a;
    logic [DW-1:0]   wd;
    oh  = N'(1 << c);
    gnt = oh;
    @(negedge clk);
    gnt = ghold;
    for (int b = 0; b <= len; b++) begin
      wd    = 32'hA5A5_0000 + 32'(b);
      cli_wdata[c*DW +: DW] = wd;
      exp_a = base + 32'(b * 4);
      mem_ready = 1'b0;
      for (int s = 0; s <= stall; s++) begin
        if (s == stall) mem_ready = 1'b1;
        #1;
        check_eq("issue_valid", 64'(mem_valid), 64'(1));
        check_eq("issue_addr", 64'(mem_addr), 64'(exp_a));
        check_eq("issue_we", 64'(mem_we), 64'(we));
        check_eq("issue_wdata", 64'(mem_wdata), 64'(wd));
        check_eq("issue_beat", 64'(cli_beat), 64'(b));
        @(negedge clk);
      end
      mem_ready  = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = rbase + 32'(b);
      #1;
      check_eq("wait_valid", 64'(mem_valid), 64'(0));
      check_eq("wait_rvalid", 64'(cli_rvalid), we ? 64'(0) : 64'(oh));
      check_eq("wait_rdata", 64'(cli_rdata), 64'(rbase + 32'(b)));
      check_eq("wait_done", 64'(cli_done), 64'(0));
      @(negedge clk);
      mem_rvalid = 1'b0;
    end
    gnt = '0;
    #1;
    check_eq("done_pulse", 64'(cli_done), 64'(oh));
    check_eq("done_rvalid", 64'(cli_rvalid), 64'(0));
    check_eq("done_valid", 64'(mem_valid), 64'(0));
    @(negedge clk);
    #1;
    check_eq("done_once", 64'(cli_done), 64'(0));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("reset_err", 64'(err), 64'(0));
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    gnt        = '0;
    cli_we     = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    for (int i = 0; i < int'(N); i++) begin
      cli_addr[i*AW +: AW]  = 32'h0F00_0000 + 32'(i * 32'h1000);
      cli_len[i*LW +: LW]   = 4'hF;
      cli_wdata[i*DW +: DW] = 32'hBAD0_0000 + 32'(i);
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_valid", 64'(mem_valid), 64'(0));
    check_eq("rst_done", 64'(cli_done), 64'(0));
    check_eq("rst_rvalid", 64'(cli_rvalid), 64'(0));
    check_eq("rst_err", 64'(err), 64'(0));
    check_eq("rst_beat", 64'(cli_beat), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single-beat read by client 2
    set_cli(2, 1'b0, 32'h0000_0100, 4'd0);
    run_burst(2, 1'b0, 32'h0000_0100, 0, 0, 32'h0000_DEAD, 7'b0000000);

    // Four-beat write by client 0 with stalls; a foreign grant mid-burst is ignored
    set_cli(0, 1'b1, 32'h0000_0040, 4'd3);
    run_burst(0, 1'b1, 32'h0000_0040, 3, 2, 32'h0000_1000, 7'b0000010);

    // Address wraps past the top of the space
    set_cli(4, 1'b0, 32'hFFFF_FFFC, 4'd1);
    run_burst(4, 1'b0, 32'hFFFF_FFFC, 1, 0, 32'h0000_2000, 7'b0000000);
    #1;
    check_eq("clean_err", 64'(err), 64'(0));
    @(negedge clk);

    // Multi-hot grant: no request, sticky error
    gnt = 7'b0000011;
    @(negedge clk);
    #1;
    check_eq("multi_valid", 64'(mem_valid), 64'(0));
    check_eq("multi_err", 64'(err), 64'(1));
    gnt = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("multi_sticky", 64'(err), 64'(1));
    check_eq("multi_idle", 64'(mem_valid), 64'(0));
    @(negedge clk);
    do_reset();

    // Stray response in IDLE
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0077;
    #1;
    check_eq("stray_rvalid", 64'(cli_rvalid), 64'(0));
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    check_eq("stray_err", 64'(err), 64'(1));
    @(negedge clk);
    do_reset();

    // Reset during WAIT of the second beat of a three-beat read
    set_cli(5, 1'b0, 32'h0000_0200, 4'd2);
    gnt = 7'b0100000;
    @(negedge clk);
    gnt       = '0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_1111;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_ready  = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check_eq("pre_rst_beat", 64'(cli_beat), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_valid", 64'(mem_valid), 64'(0));
    check_eq("abort_addr", 64'(mem_addr), 64'(0));
    check_eq("abort_done", 64'(cli_done), 64'(0));
    check_eq("abort_rvalid", 64'(cli_rvalid), 64'(0));
    check_eq("abort_beat", 64'(cli_beat), 64'(0));
    check_eq("abort_err", 64'(err), 64'(0));
    @(negedge clk);
    #1;
    check_eq("abort_no_done", 64'(cli_done), 64'(0));
    check_eq("abort_idle", 64'(mem_valid), 64'(0));
    @(negedge clk);
    run_burst(5, 1'b0, 32'h0000_0200, 2, 1, 32'h0000_3000, 7'b0000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
